// File: rtl/riscv_crypto_fu_aes32_pipe.sv
// Two-stage pipelined RISC-V AES32 functional unit (aes32esi/esmi/dsi/dsmi).
// Stage 1 holds the S-box output; stage 2 holds the finished rd value.

module riscv_crypto_aes_sbox (
    input  logic       dec,
    input  logic [7:0] din,
    output logic [7:0] dout
);
    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] sh;
        acc = 8'h00;
        sh  = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ sh;
            sh = {sh[6:0], 1'b0} ^ (sh[7] ? 8'h1b : 8'h00);
        end
        return acc;
    endfunction

    // Multiplicative inverse as a^254; maps 0 to 0 as AES requires.
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] x, input int unsigned n);
        logic [15:0] t;
        t = {x, x} << n;
        return t[15:8];
    endfunction

    logic [7:0] inv_aff;
    logic [7:0] inv_in;
    logic [7:0] inv_out;
    logic [7:0] fwd_aff;

    // One shared inverter: inverse affine precedes it on decrypt, forward affine follows it on encrypt.
    always_comb begin
        inv_aff = rotl8(din, 1) ^ rotl8(din, 3) ^ rotl8(din, 6) ^ 8'h05;
        inv_in  = dec ? inv_aff : din;
        inv_out = gf_inv(inv_in);
        fwd_aff = inv_out ^ rotl8(inv_out, 1) ^ rotl8(inv_out, 2) ^ rotl8(inv_out, 3)
                ^ rotl8(inv_out, 4) ^ 8'h63;
        dout    = dec ? inv_out : fwd_aff;
    end
endmodule

module riscv_crypto_fu_aes32_pipe #(
    parameter int unsigned TAG_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_dec,
    input  logic             in_mix,
    input  logic [1:0]       in_bs,
    input  logic [31:0]      in_rs1,
    input  logic [31:0]      in_rs2,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_result,
    output logic [TAG_W-1:0] out_tag
);
    function automatic logic [7:0] xtime(input logic [7:0] x);
        return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
    endfunction

    logic             s1_valid_q, s1_valid_d;
    logic [7:0]       so_q, so_d;
    logic [1:0]       bs_q, bs_d;
    logic             dec_q, dec_d;
    logic             mix_q, mix_d;
    logic [31:0]      rs1_q, rs1_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic             s2_valid_q, s2_valid_d;
    logic [31:0]      out_result_q, out_result_d;
    logic [TAG_W-1:0] out_tag_q, out_tag_d;

    logic       s2_adv, s1_adv, accept;
    logic [7:0] sbox_in, sbox_out;
    logic [7:0] x2, x4, x8;
    logic [31:0] mixed, rotated, result_c;

    assign s2_adv   = !s2_valid_q || out_ready;
    assign s1_adv   = !s1_valid_q || s2_adv;
    assign in_ready = s1_adv && !rst && !flush;
    assign accept   = in_valid && in_ready;

    always_comb begin
        unique case (in_bs)
            2'd0:    sbox_in = in_rs2[7:0];
            2'd1:    sbox_in = in_rs2[15:8];
            2'd2:    sbox_in = in_rs2[23:16];
            default: sbox_in = in_rs2[31:24];
        endcase
    end

    riscv_crypto_aes_sbox u_sbox (
        .dec  (in_dec),
        .din  (sbox_in),
        .dout (sbox_out)
    );

    // Partial (Inv)MixColumn column, rotation into place and accumulate into rs1.
    always_comb begin
        x2 = xtime(so_q);
        x4 = xtime(x2);
        x8 = xtime(x4);
        if (!mix_q) begin
            mixed = {24'h000000, so_q};
        end else if (!dec_q) begin
            mixed = {x2 ^ so_q, so_q, so_q, x2};
        end else begin
            mixed = {x8 ^ x2 ^ so_q, x8 ^ x4 ^ so_q, x8 ^ so_q, x8 ^ x4 ^ x2};
        end
        unique case (bs_q)
            2'd0:    rotated = mixed;
            2'd1:    rotated = {mixed[23:0], mixed[31:24]};
            2'd2:    rotated = {mixed[15:0], mixed[31:16]};
            default: rotated = {mixed[7:0], mixed[31:8]};
        endcase
        result_c = rs1_q ^ rotated;
    end

    always_comb begin
        s1_valid_d   = s1_valid_q;
        so_d         = so_q;
        bs_d         = bs_q;
        dec_d        = dec_q;
        mix_d        = mix_q;
        rs1_d        = rs1_q;
        tag_d        = tag_q;
        s2_valid_d   = s2_valid_q;
        out_result_d = out_result_q;
        out_tag_d    = out_tag_q;

        if (s1_adv) s1_valid_d = accept;
        if (accept) begin
            so_d  = sbox_out;
            bs_d  = in_bs;
            dec_d = in_dec;
            mix_d = in_mix;
            rs1_d = in_rs1;
            tag_d = in_tag;
        end

        if (s2_adv) begin
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = result_c;
                out_tag_d    = tag_q;
            end
        end

        if (rst || flush) begin
            s1_valid_d = 1'b0;
            s2_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q   <= 1'b0;
            so_q         <= 8'h00;
            bs_q         <= 2'd0;
            dec_q        <= 1'b0;
            mix_q        <= 1'b0;
            rs1_q        <= 32'h0;
            tag_q        <= TAG_W'(0);
            s2_valid_q   <= 1'b0;
            out_result_q <= 32'h0;
            out_tag_q    <= TAG_W'(0);
        end else begin
            s1_valid_q   <= s1_valid_d;
            so_q         <= so_d;
            bs_q         <= bs_d;
            dec_q        <= dec_d;
            mix_q        <= mix_d;
            rs1_q        <= rs1_d;
            tag_q        <= tag_d;
            s2_valid_q   <= s2_valid_d;
            out_result_q <= out_result_d;
            out_tag_q    <= out_tag_d;
        end
    end

    assign out_valid  = s2_valid_q;
    assign out_result = out_result_q;
    assign out_tag    = out_tag_q;
endmodule

// File: tb/tb_riscv_crypto_fu_aes32_pipe.sv
// Scoreboard bench for riscv_crypto_fu_aes32_pipe: directed AES32 vectors, backpressure, flush/reset, exhaustive sweep.

module tb_riscv_crypto_fu_aes32_pipe;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic        in_dec = 1'b0;
    logic        in_mix = 1'b0;
    logic [1:0]  in_bs = 2'd0;
    logic [31:0] in_rs1 = 32'h0;
    logic [31:0] in_rs2 = 32'h0;
    logic [4:0]  in_tag = 5'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] out_result;
    logic [4:0]  out_tag;

    riscv_crypto_fu_aes32_pipe #(.TAG_W(5)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dec(in_dec), .in_mix(in_mix), .in_bs(in_bs),
        .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_result(out_result), .out_tag(out_tag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  tag;
        int          cyc;
    } exp_t;

    exp_t        sbq[$];
    logic [7:0]  sbox_t [256];
    logic [7:0]  isbox_t [256];
    int          errs = 0;
    int          checks = 0;
    int          cyc = 0;
    logic        lat_chk = 1'b0;
    logic        hold_pend = 1'b0;
    logic [31:0] hold_res;
    logic [4:0]  hold_tag;

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%08h want 0x%08h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= x;
            x = x[7] ? (8'(x << 1) ^ 8'h1b) : 8'(x << 1);
        end
        return p;
    endfunction

    // Tables built from brute-force inversion plus the bitwise affine map.
    task automatic build_tables();
        logic [7:0] inv, b;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            for (int i = 0; i < 8; i++)
                b[i] = inv[i] ^ inv[(i + 4) % 8] ^ inv[(i + 5) % 8] ^ inv[(i + 6) % 8]
                     ^ inv[(i + 7) % 8];
            sbox_t[x] = b ^ 8'h63;
        end
        for (int x = 0; x < 256; x++) isbox_t[sbox_t[x]] = 8'(x);
    endtask

    function automatic logic [31:0] model(input logic dec, input logic mix, input logic [1:0] bs,
                                          input logic [31:0] rs1, input logic [31:0] rs2);
        logic [7:0]  si, so;
        logic [31:0] m;
        logic [63:0] mm;
        int          s;
        s  = 8 * int'(bs);
        si = rs2[s +: 8];
        so = dec ? isbox_t[si] : sbox_t[si];
        if (!mix)     m = {24'h0, so};
        else if (!dec) m = {gmul(so, 8'h03), so, so, gmul(so, 8'h02)};
        else          m = {gmul(so, 8'h0b), gmul(so, 8'h0d), gmul(so, 8'h09), gmul(so, 8'h0e)};
        mm = {m, m} >> (32 - s);
        return rs1 ^ mm[31:0];
    endfunction

    function automatic logic pick_ordy(input int mode);
        if (mode == 0) return 1'b1;
        if (mode == 2) return 1'b0;
        return $urandom_range(0, 3) != 0;
    endfunction

    // One cycle: drive at negedge, sample 1ns later, score outputs, record accepts.
    task automatic step(input logic v, input logic dec, input logic mix, input logic [1:0] bs,
                        input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag,
                        input logic [31:0] exp, input logic ordy, input logic fl, input logic rs,
                        output logic acc);
        exp_t e;
        @(negedge clk);
        in_valid = v; in_dec = dec; in_mix = mix; in_bs = bs;
        in_rs1 = rs1; in_rs2 = rs2; in_tag = tag;
        out_ready = ordy; flush = fl; rst = rs;
        #1;
        if (hold_pend) begin
            check_eq("hold_valid", 32'(out_valid), 1);
            check_eq("hold_result", out_result, hold_res);
            check_eq("hold_tag", 32'(out_tag), 32'(hold_tag));
        end
        if (rs || fl) check_eq("in_ready_clr", 32'(in_ready), 0);
        else check_eq("in_ready", 32'(in_ready), 32'(!(sbq.size() == 2 && !ordy)));
        if (sbq.size() == 0) check_eq("out_valid_idle", 32'(out_valid), 0);
        acc = v && in_ready && !rs && !fl;
        if (rs || fl) begin
            sbq.delete();
            hold_pend = 1'b0;
        end else begin
            if (out_valid && ordy && sbq.size() > 0) begin
                e = sbq.pop_front();
                check_eq("result", out_result, e.res);
                check_eq("tag", 32'(out_tag), 32'(e.tag));
                if (lat_chk) check_eq("latency", 32'(cyc - e.cyc), 2);
            end
            hold_pend = out_valid && !ordy;
            hold_res  = out_result;
            hold_tag  = out_tag;
            if (acc) sbq.push_back('{res: exp, tag: tag, cyc: cyc});
        end
        cyc++;
    endtask

    task automatic issue(input logic dec, input logic mix, input logic [1:0] bs,
                         input logic [31:0] rs1, input logic [31:0] rs2, input logic [4:0] tag,
                         input logic [31:0] exp, input int mode);
        logic acc;
        int   n;
        acc = 1'b0;
        n = 0;
        while (!acc && n < 50) begin
            step(1'b1, dec, mix, bs, rs1, rs2, tag, exp, pick_ordy(mode), 1'b0, 1'b0, acc);
            n++;
        end
        if (!acc) check_eq("issue_timeout", 32'(acc), 1);
    endtask

    task automatic idle(input int mode);
        logic acc;
        step(1'b0, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, pick_ordy(mode), 1'b0, 1'b0, acc);
    endtask

    task automatic drain(input int mode);
        int n;
        n = 0;
        while (sbq.size() > 0 && n < 100) begin
            idle(mode);
            n++;
        end
        check_eq("drain_timeout", 32'(sbq.size()), 0);
    endtask

    task automatic kill_test(input logic use_rst);
        logic acc;
        lat_chk = 1'b0;
        issue(1'b0, 1'b1, 2'd0, 32'h11111111, 32'h0, 5'd20, 32'h0, 2);
        issue(1'b1, 1'b1, 2'd1, 32'h22222222, 32'h0, 5'd21, 32'h0, 2);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd22, 32'h0, 1'b1, !use_rst, use_rst, acc);
        idle(0);
        check_eq("kill_out_valid", 32'(out_valid), 0);
        if (use_rst) check_eq("kill_rst_result", out_result, 0);
        idle(0);
        idle(0);
        lat_chk = 1'b1;
        issue(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd23, 32'h00000063, 0);
        drain(0);
    endtask

    initial begin
        logic        acc;
        logic [31:0] rs1, rs2;
        logic        dec, mix;
        int          k;
        build_tables();

        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        step(1'b1, 1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd0, 32'h0, 1'b1, 1'b0, 1'b1, acc);
        check_eq("rst_result", out_result, 0);
        check_eq("rst_tag", 32'(out_tag), 0);

        lat_chk = 1'b1;
        issue(1'b0, 1'b0, 2'd0, 32'h0, 32'h0, 5'd1, 32'h00000063, 0);
        issue(1'b0, 1'b1, 2'd0, 32'h0, 32'h0, 5'd2, 32'hA56363C6, 0);
        issue(1'b0, 1'b1, 2'd1, 32'h0, 32'h0, 5'd3, 32'h6363C6A5, 0);
        issue(1'b0, 1'b1, 2'd3, 32'h0, 32'h0, 5'd4, 32'hC6A56363, 0);
        issue(1'b1, 1'b0, 2'd0, 32'h0, 32'h0, 5'd5, 32'h00000052, 0);
        issue(1'b1, 1'b1, 2'd0, 32'h0, 32'h0, 5'd6, 32'h50A7F451, 0);
        issue(1'b1, 1'b1, 2'd0, 32'hFFFFFFFF, 32'h0, 5'd7, 32'hAF580BAE, 0);
        drain(0);

        lat_chk = 1'b0;
        for (int t = 0; t < 8; t++) begin
            rs1 = $urandom; rs2 = $urandom;
            dec = 1'($urandom); mix = 1'($urandom);
            issue(dec, mix, 2'(t), rs1, rs2, 5'(t), model(dec, mix, 2'(t), rs1, rs2), 1);
        end
        drain(1);

        kill_test(1'b0);
        kill_test(1'b1);

        lat_chk = 1'b0;
        k = 0;
        for (int v = 0; v < 256; v++) begin
            for (int bs = 0; bs < 4; bs++) begin
                for (int op = 0; op < 4; op++) begin
                    rs1 = $urandom;
                    rs2 = $urandom;
                    rs2[8 * bs +: 8] = 8'(v);
                    dec = op[1];
                    mix = op[0];
                    issue(dec, mix, 2'(bs), rs1, rs2, 5'(k), model(dec, mix, 2'(bs), rs1, rs2), 1);
                    k++;
                end
            end
        end
        drain(1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule

// File: doc/riscv_crypto_fu_aes32_pipe.md
# riscv_crypto_fu_aes32_pipe

Two-stage pipelined functional unit executing the RISC-V scalar AES32 instructions (aes32esi, aes32esmi, aes32dsi, aes32dsmi). It sits between the issue stage and writeback. It selects one byte of rs2, pushes it through the shared forward/inverse AES S-box (riscv_crypto_aes_sbox), then applies the partial (Inv)MixColumn, rotation and rs1 XOR. Valid/ready handshakes on both sides give 1 result/cycle throughput with full backpressure.

## Interface
Parameters:
- TAG_W, 5, width of the destination-register tag carried alongside each operation.

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- flush  in  1  discards all in-flight operations (synchronous).
- in_valid  in  1  operation offered.
- in_ready  out  1  unit accepts the operation this cycle.
- in_dec  in  1  0 = encrypt (forward S-box), 1 = decrypt (inverse S-box).
- in_mix  in  1  1 = middle round (esmi/dsmi), 0 = final round (esi/dsi).
- in_bs  in  2  byte select.
- in_rs1  in  32  accumulator operand.
- in_rs2  in  32  source-byte operand.
- in_tag  in  TAG_W  opaque tag, returned unchanged.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result this cycle.
- out_result  out  32  rd value.
- out_tag  out  TAG_W  tag of the result.

## Operation
- shamt = 8·bs. si = rs2[shamt+7 : shamt]. so = S(si) when dec=0, S⁻¹(si) when dec=1.
- Mixed word, bits [31:24],[23:16],[15:8],[7:0]:
  - enc, mix=1: {3·so, so, so, 2·so}.
  - dec, mix=1: {0B·so, 0D·so, 09·so, 0E·so}.
  - mix=0: {0, 0, 0, so}.
- GF(2⁸) multiply modulo x⁸+x⁴+x³+x+1 (xtime: shift left, XOR 0x1B on carry-out).
- result = rs1 XOR rotl32(mixed, shamt).
- Stage 1 (S1) registers: so, bs, dec, mix, rs1, tag, s1_valid. One S-box instance only, driven combinationally from the input port.
- Stage 2 (S2) registers: out_result, out_tag, s2_valid (= out_valid). MixColumn/rotate/XOR are computed from S1 registers.
- Advance rules: s2_adv = !s2_valid | out_ready. s1_adv = !s1_valid | s2_adv. in_ready = s1_adv & !rst & !flush.
- Accept: in_valid & in_ready loads S1. When S1 is valid and s2_adv, S1 moves into S2. A stalled stage holds all of its registers unchanged.
- Output hold: while out_valid & !out_ready, out_result and out_tag stay stable.

## Timing
- Latency: operation accepted in cycle N → out_valid in cycle N+2 when there is no backpressure.
- Throughput: 1 op/cycle with out_ready held high. Simultaneous accept and output transfer in the same cycle is legal and loses no data.
- Reset: s1_valid=0, out_valid=0, out_result=0, out_tag=0, S1 data=0. in_ready=0 while rst is high and 1 in the first cycle after.
- Reset or flush in the middle of an operation: both valid bits clear next cycle. An input offered in the flush cycle is not accepted.
- Full pipe with out_ready=0: in_ready=0. Releasing out_ready for one cycle frees one slot, and in_ready rises in that same cycle.
- in_* are ignored when in_valid=0. S1/S2 data registers may change only when their valid bit is loaded.

## Test plan
- Encrypt final: rs1=0, rs2=0, bs=0, dec=0, mix=0 → out_result=0x00000063 exactly 2 cycles after accept.
- Encrypt middle, rotation: rs2=0, mix=1, dec=0, rs1=0. bs=0 → 0xA56363C6. bs=1 → 0x6363C6A5. bs=3 → 0xC6A56363.
- Decrypt: rs2=0, dec=1. mix=0 → 0x00000052. mix=1, bs=0 → 0x50A7F451. With rs1=0xFFFFFFFF, mix=1, bs=0 → 0xAF580BAE.
- Backpressure streaming: issue 8 back-to-back ops with tags 0..7 while out_ready toggles pseudo-randomly. Results and tags must arrive in order with none lost or duplicated, and in_ready must be low exactly when both stages are held.
- Flush/reset: with 2 ops in flight, pulse flush (then repeat with rst). out_valid=0 next cycle and the in-flight tags never appear. A new op issued afterwards completes in 2 cycles.
- Exhaustive: all 256 rs2 bytes × 4 bs × 4 ops with random rs1 → compare against a software AES32 model.
